// File: rtl/opcode_cycle_sequencer_if.sv
// ---------------------------------------------------------------------------
// opcode_cycle_sequencer_if
//
// Purpose:
//   Bundles the handshake, bus and decode signals of the opcode/cycle
//   sequencer into one interface. Clock and reset stay outside as plain ports.
//
// Parameters:
//   MAX_MCYCLES   number of M-cycle slots (width of o_Cycle_Count)
//
// Signal summary:
//   i_Wait            memory wait, 1 = hold all sequencer state
//   i_Fetch           OR of group decoders' fetch, sampled at T4
//   i_Data_Bus[7:0]   opcode byte from the data bus
//   i_Flags[3:0]      {Z,N,H,C}
//   o_Cycle_Step[3:0] one-hot T-state (bit0 = T1)
//   o_Cycle_Count     one-hot M-cycle index (bit0 = M1)
//   o_X/o_Y/o_Z/o_P/o_Q   one-hot opcode field decodes
//   o_Conditions[3:0] {C, ~C, Z, ~Z}
//   o_Opcode[7:0]     raw instruction register
//   o_Sequence_Error  sticky overrun flag
//   o_CB_Prefix       current instruction is CB-prefixed
//
// Modports:
//   master  drives the inputs and observes the outputs (bench / upstream)
//   slave   the sequencer itself
// ---------------------------------------------------------------------------
interface opcode_cycle_sequencer_if #(
    parameter int MAX_MCYCLES = 8
);
    logic                   i_Wait;
    logic                   i_Fetch;
    logic [7:0]             i_Data_Bus;
    logic [3:0]             i_Flags;
    logic [3:0]             o_Cycle_Step;
    logic [MAX_MCYCLES-1:0] o_Cycle_Count;
    logic [3:0]             o_X;
    logic [7:0]             o_Y;
    logic [7:0]             o_Z;
    logic [3:0]             o_P;
    logic [1:0]             o_Q;
    logic [3:0]             o_Conditions;
    logic [7:0]             o_Opcode;
    logic                   o_Sequence_Error;
    logic                   o_CB_Prefix;

    modport master (
        output i_Wait,
        output i_Fetch,
        output i_Data_Bus,
        output i_Flags,
        input  o_Cycle_Step,
        input  o_Cycle_Count,
        input  o_X,
        input  o_Y,
        input  o_Z,
        input  o_P,
        input  o_Q,
        input  o_Conditions,
        input  o_Opcode,
        input  o_Sequence_Error,
        input  o_CB_Prefix
    );

    modport slave (
        input  i_Wait,
        input  i_Fetch,
        input  i_Data_Bus,
        input  i_Flags,
        output o_Cycle_Step,
        output o_Cycle_Count,
        output o_X,
        output o_Y,
        output o_Z,
        output o_P,
        output o_Q,
        output o_Conditions,
        output o_Opcode,
        output o_Sequence_Error,
        output o_CB_Prefix
    );
endinterface

// File: rtl/opcode_cycle_sequencer.sv
// ---------------------------------------------------------------------------
// opcode_cycle_sequencer
//
// Purpose:
//   Upstream stage of the X0..X3 group decoders. Holds the instruction
//   register, decodes it into one-hot X/Y/Z/P/Q fields, and generates the
//   one-hot T-state (Cycle_Step) and M-cycle (Cycle_Count) timing. The OR of
//   the group decoders' fetch outputs (i_Fetch) tells it when the current
//   M-cycle is the last one, so the next opcode is loaded at that T4 edge.
//   It also derives the four branch-condition bits from the flag register.
//
// Parameters:
//   MAX_MCYCLES   number of M-cycle slots, width of o_Cycle_Count (default 8)
//
// Ports:
//   i_Clk     in   system clock, rising-edge
//   i_Reset   in   asynchronous active-high reset
//   bus       slave modport of opcode_cycle_sequencer_if, carrying
//             i_Wait, i_Fetch, i_Data_Bus, i_Flags and all o_* outputs
//
// Configuration macro:
//   CB_PREFIX_EN  when defined, a fetched 8'hCB executes as a one-M-cycle
//                 NOP-decoded prefix byte and flags the following
//                 instruction through o_CB_Prefix. When undefined,
//                 o_CB_Prefix is tied low and 8'hCB is an ordinary X3 opcode.
// ---------------------------------------------------------------------------
module opcode_cycle_sequencer #(
    parameter int MAX_MCYCLES = 8
) (
    input  logic                        i_Clk,
    input  logic                        i_Reset,
    opcode_cycle_sequencer_if.slave     bus
);

    localparam logic [3:0]             STEP_T1  = 4'b0001;
    localparam logic [MAX_MCYCLES-1:0] COUNT_M1 = MAX_MCYCLES'(1);
    localparam logic [7:0]             CB_BYTE  = 8'hCB;

    // Sequencer state
    logic [3:0]             r_Step;
    logic [MAX_MCYCLES-1:0] r_Count;
    logic [7:0]             r_IR;
    logic                   r_SeqError;

    // Registered one-hot decodes, loaded together with the IR
    logic [3:0]             r_X;
    logic [7:0]             r_Y;
    logic [7:0]             r_Z;
    logic [3:0]             r_P;
    logic [1:0]             r_Q;

    // Control qualifiers
    logic                   w_Advance;
    logic                   w_AtT4;
    logic                   w_FetchNow;
    logic                   w_NextMCycle;
    logic                   w_CountAtMax;

    // Prefix handling results
    logic                   w_PrefixStart;
    logic [7:0]             w_DecodeByte;

    // Wait has priority over everything, so every state update is gated by
    // w_Advance. Fetch is only meaningful on the T4 edge; at T1..T3 it is
    // ignored entirely.
    assign w_Advance    = ~bus.i_Wait;
    assign w_AtT4       = r_Step[3];
    assign w_FetchNow   = w_Advance & w_AtT4 & bus.i_Fetch;
    assign w_NextMCycle = w_Advance & w_AtT4 & ~bus.i_Fetch;
    assign w_CountAtMax = r_Count[MAX_MCYCLES-1];

`ifdef CB_PREFIX_EN
    // r_CB_Pending marks that the CB prefix byte itself is the instruction
    // currently executing. While it is set, the next fetched byte is the
    // CB-table opcode, even if that byte is another 8'hCB.
    logic r_CB_Pending;
    logic r_CB_Prefix;

    assign w_PrefixStart = ~r_CB_Pending & (bus.i_Data_Bus == CB_BYTE);

    // On every fetch the prefix flags are recomputed: entering the prefix
    // byte arms both, loading the CB-table opcode keeps the prefix flag but
    // drops pending, and any other fetch clears both.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            r_CB_Pending <= 1'b0;
            r_CB_Prefix  <= 1'b0;
        end else if (w_FetchNow) begin
            r_CB_Pending <= w_PrefixStart;
            r_CB_Prefix  <= w_PrefixStart | r_CB_Pending;
        end
    end

    assign bus.o_CB_Prefix = r_CB_Prefix;
`else
    assign w_PrefixStart   = 1'b0;
    assign bus.o_CB_Prefix = 1'b0;
`endif

    // The prefix byte must look like a NOP to the group decoders so that
    // they fetch again at the end of M1; the raw IR still shows 8'hCB.
    assign w_DecodeByte = w_PrefixStart ? 8'h00 : bus.i_Data_Bus;

    // T-state ring: a one-hot rotate that can never become zero or
    // multi-hot because it only ever moves the single set bit.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            r_Step <= STEP_T1;
        end else if (w_Advance) begin
            r_Step <= {r_Step[2:0], r_Step[3]};
        end
    end

    // M-cycle counter: restarts at M1 on a fetch, otherwise walks one slot
    // per T4. At the last slot it saturates rather than wrapping, so an
    // instruction that never fetches stays visibly stuck at MAX.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            r_Count <= COUNT_M1;
        end else if (w_FetchNow) begin
            r_Count <= COUNT_M1;
        end else if (w_NextMCycle && !w_CountAtMax) begin
            r_Count <= {r_Count[MAX_MCYCLES-2:0], 1'b0};
        end
    end

    // Overrun detection: running past the final slot without a fetch means
    // the group decoders lost track of the instruction. Only reset clears it.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            r_SeqError <= 1'b0;
        end else if (w_NextMCycle && w_CountAtMax) begin
            r_SeqError <= 1'b1;
        end
    end

    // Instruction register and its decodes are loaded on the same edge so
    // the decodes carry no extra latency: they are valid from T1 of M1.
    // Reset leaves a NOP in the IR, so the first real fetch happens at the
    // end of the first M-cycle.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            r_IR <= 8'h00;
            r_X  <= 4'b0001;
            r_Y  <= 8'h01;
            r_Z  <= 8'h01;
            r_P  <= 4'b0001;
            r_Q  <= 2'b01;
        end else if (w_FetchNow) begin
            r_IR <= bus.i_Data_Bus;
            r_X  <= 4'b0001 << w_DecodeByte[7:6];
            r_Y  <= 8'h01   << w_DecodeByte[5:3];
            r_Z  <= 8'h01   << w_DecodeByte[2:0];
            r_P  <= 4'b0001 << w_DecodeByte[5:4];
            r_Q  <= 2'b01   << w_DecodeByte[3];
        end
    end

    // Branch conditions come straight from the flags with no register:
    // bit0 NZ, bit1 Z, bit2 NC, bit3 C, where Z = F[7] and C = F[4].
    assign bus.o_Conditions = {bus.i_Flags[0], ~bus.i_Flags[0],
                               bus.i_Flags[3], ~bus.i_Flags[3]};

    assign bus.o_Cycle_Step     = r_Step;
    assign bus.o_Cycle_Count    = r_Count;
    assign bus.o_Opcode         = r_IR;
    assign bus.o_Sequence_Error = r_SeqError;
    assign bus.o_X              = r_X;
    assign bus.o_Y              = r_Y;
    assign bus.o_Z              = r_Z;
    assign bus.o_P              = r_P;
    assign bus.o_Q              = r_Q;

endmodule

// File: tb/tb_opcode_cycle_sequencer.sv
// ---------------------------------------------------------------------------
// tb_opcode_cycle_sequencer
//
// Purpose:
//   Self-checking bench for opcode_cycle_sequencer. A behavioural model
//   tracks the T-state and M-cycle as plain integers plus the current opcode
//   and prefix status, and the expected one-hot outputs are computed from
//   those. Directed sequences cover reset, fetch decode, multi-M-cycle
//   pacing, wait hold, overrun saturation and the CB prefix; a randomized
//   phase follows.
// ---------------------------------------------------------------------------
module tb_opcode_cycle_sequencer;

    localparam int MAXM = 8;

    logic clk;
    logic rst;

    int checks;
    int failures;

    // Behavioural model state
    int         mT;      // 0..3 -> T1..T4
    int         mM;      // 0..MAXM-1 -> M1..Mmax
    logic [7:0] mIr;
    bit         mErr;
    bit         mPfx;
    bit         mPend;

    opcode_cycle_sequencer_if #(.MAX_MCYCLES(MAXM)) seqIf ();

    opcode_cycle_sequencer #(.MAX_MCYCLES(MAXM)) dut (
        .i_Clk   (clk),
        .i_Reset (rst),
        .bus     (seqIf)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global safety net in case a wait is ever left unbounded.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        mT    = 0;
        mM    = 0;
        mIr   = 8'h00;
        mErr  = 0;
        mPfx  = 0;
        mPend = 0;
    endtask

    // One non-reset clock edge of the reference behaviour.
    task automatic modelClock(input logic w, input logic f, input logic [7:0] b);
        if (w) return;
        if (mT == 3) begin
            if (f) begin
                mIr = b;
                mM  = 0;
`ifdef CB_PREFIX_EN
                if (mPend) begin
                    mPend = 0;
                    mPfx  = 1;
                end else if (b == 8'hCB) begin
                    mPend = 1;
                    mPfx  = 1;
                end else begin
                    mPfx = 0;
                end
`endif
            end else if (mM == MAXM - 1) begin
                mErr = 1;
            end else begin
                mM = mM + 1;
            end
        end
        mT = (mT + 1) % 4;
    endtask

    // Compare every DUT output against the model's view.
    task automatic checkAll(input string tag);
        logic [7:0] eff;
        logic [3:0] fl;
        logic [3:0] cond;
        eff = mPend ? 8'h00 : mIr;
        fl  = seqIf.i_Flags;
        cond[0] = (fl[3] == 1'b0);
        cond[1] = (fl[3] == 1'b1);
        cond[2] = (fl[0] == 1'b0);
        cond[3] = (fl[0] == 1'b1);
        checkOutput({tag, "_step"},  32'(seqIf.o_Cycle_Step),     32'(1) << mT);
        checkOutput({tag, "_count"}, 32'(seqIf.o_Cycle_Count),    32'(1) << mM);
        checkOutput({tag, "_X"},     32'(seqIf.o_X),              32'(1) << (eff / 64));
        checkOutput({tag, "_Y"},     32'(seqIf.o_Y),              32'(1) << ((eff / 8) % 8));
        checkOutput({tag, "_Z"},     32'(seqIf.o_Z),              32'(1) << (eff % 8));
        checkOutput({tag, "_P"},     32'(seqIf.o_P),              32'(1) << ((eff / 16) % 4));
        checkOutput({tag, "_Q"},     32'(seqIf.o_Q),              32'(1) << ((eff / 8) % 2));
        checkOutput({tag, "_op"},    32'(seqIf.o_Opcode),         32'(mIr));
        checkOutput({tag, "_err"},   32'(seqIf.o_Sequence_Error), 32'(mErr));
        checkOutput({tag, "_pfx"},   32'(seqIf.o_CB_Prefix),      32'(mPfx));
        checkOutput({tag, "_cond"},  32'(seqIf.o_Conditions),     32'(cond));
    endtask

    // Drive one clock of inputs (entered at a negedge), advance the model
    // at the rising edge, then check at the following falling edge.
    task automatic applyStimulus(input logic w, input logic f,
                                 input logic [7:0] b, input logic [3:0] fl);
        seqIf.i_Wait     = w;
        seqIf.i_Fetch    = f;
        seqIf.i_Data_Bus = b;
        seqIf.i_Flags    = fl;
        @(posedge clk);
        if (!rst) modelClock(w, f, b);
        @(negedge clk);
        checkAll("cyc");
    endtask

    // Async reset asserted between edges; outputs must be at reset values
    // while reset is still high.
    task automatic doReset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        modelReset();
        checkAll(tag);
        @(negedge clk);
        rst = 1'b0;
        checkAll({tag, "_rel"});
    endtask

    // Idle clocks with no fetch until the model sits at T4 (bounded).
    task automatic runToT4();
        for (int i = 0; i < 4 && mT != 3; i++)
            applyStimulus(1'b0, 1'b0, 8'h00, 4'($urandom));
        if (mT != 3) checkOutput("runToT4_timeout", 32'(mT), 32'd3);
    endtask

    task automatic fetchByte(input logic [7:0] b);
        runToT4();
        applyStimulus(1'b0, 1'b1, b, 4'($urandom));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        seqIf.i_Wait     = 1'b0;
        seqIf.i_Fetch    = 1'b0;
        seqIf.i_Data_Bus = 8'h00;
        seqIf.i_Flags    = 4'h0;
        modelReset();
        #1;
        checkAll("por");
        @(negedge clk);
        rst = 1'b0;

        // Fetch 0x31 at the first T4.
        fetchByte(8'h31);
        checkOutput("t2_X",     32'(seqIf.o_X),           32'h1);
        checkOutput("t2_Z",     32'(seqIf.o_Z),           32'h02);
        checkOutput("t2_P",     32'(seqIf.o_P),           32'h8);
        checkOutput("t2_Q",     32'(seqIf.o_Q),           32'h1);
        checkOutput("t2_count", 32'(seqIf.o_Cycle_Count), 32'h01);
        checkOutput("t2_step",  32'(seqIf.o_Cycle_Step),  32'h1);

        // Three-M-cycle instruction paced at four clocks per M-cycle.
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 8'h55, 4'($urandom));
        checkOutput("t3_M2", 32'(seqIf.o_Cycle_Count), 32'h02);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 8'h55, 4'($urandom));
        checkOutput("t3_M3", 32'(seqIf.o_Cycle_Count), 32'h04);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 8'h55, 4'($urandom));
        checkOutput("t3_M3_hold", 32'(seqIf.o_Cycle_Count), 32'h04);
        applyStimulus(1'b0, 1'b1, 8'h00, 4'($urandom));
        checkOutput("t3_M1", 32'(seqIf.o_Cycle_Count), 32'h01);

        // Reset in the middle of M3 of another instruction.
        fetchByte(8'h3E);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 8'h00, 4'($urandom));
        checkOutput("t1_pre_M3", 32'(seqIf.o_Cycle_Count), 32'h04);
        doReset("t1_rst");
        checkOutput("t1_X", 32'(seqIf.o_X), 32'h1);
        checkOutput("t1_op", 32'(seqIf.o_Opcode), 32'h00);

        // Wait for five clocks at T2 of M2, with fetch asserted under wait.
        runToT4();
        applyStimulus(1'b0, 1'b0, 8'h00, 4'($urandom));
        applyStimulus(1'b0, 1'b0, 8'h00, 4'($urandom));
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b1, 8'hC3, 4'($urandom));
            checkOutput("t4_step_hold",  32'(seqIf.o_Cycle_Step),  32'h2);
            checkOutput("t4_count_hold", 32'(seqIf.o_Cycle_Count), 32'h02);
        end
        applyStimulus(1'b0, 1'b0, 8'h00, 4'($urandom));
        checkOutput("t4_resume", 32'(seqIf.o_Cycle_Step), 32'h4);

        // Overrun: no fetch for 40 clocks from a fresh reset.
        doReset("t5_rst");
        for (int i = 0; i < 40; i++) applyStimulus(1'b0, 1'b0, 8'h00, 4'($urandom));
        checkOutput("t5_count", 32'(seqIf.o_Cycle_Count),    32'h80);
        checkOutput("t5_err",   32'(seqIf.o_Sequence_Error), 32'h1);
        fetchByte(8'h00);
        fetchByte(8'h00);
        checkOutput("t5_sticky", 32'(seqIf.o_Sequence_Error), 32'h1);
        doReset("t5_clr");
        checkOutput("t5_cleared", 32'(seqIf.o_Sequence_Error), 32'h0);

        // CB handling.
        fetchByte(8'hCB);
`ifdef CB_PREFIX_EN
        checkOutput("t6_cb_X",   32'(seqIf.o_X),         32'h1);
        checkOutput("t6_cb_pfx", 32'(seqIf.o_CB_Prefix), 32'h1);
        checkOutput("t6_cb_op",  32'(seqIf.o_Opcode),    32'hCB);
        fetchByte(8'h7C);
        checkOutput("t6_7c_X",   32'(seqIf.o_X),         32'h2);
        checkOutput("t6_7c_pfx", 32'(seqIf.o_CB_Prefix), 32'h1);
        fetchByte(8'h00);
        checkOutput("t6_clr_pfx", 32'(seqIf.o_CB_Prefix), 32'h0);
        fetchByte(8'hCB);
        fetchByte(8'hCB);
        checkOutput("t6_cbcb_X",   32'(seqIf.o_X),         32'h8);
        checkOutput("t6_cbcb_pfx", 32'(seqIf.o_CB_Prefix), 32'h1);
`else
        checkOutput("t6_cb_X",   32'(seqIf.o_X),         32'h8);
        checkOutput("t6_cb_pfx", 32'(seqIf.o_CB_Prefix), 32'h0);
`endif

        // Randomized phase against the model.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                doReset("rnd_rst");
            end else begin
                applyStimulus(($urandom_range(0, 4) == 0),
                              ($urandom_range(0, 2) == 0),
                              ($urandom_range(0, 5) == 0) ? 8'hCB : 8'($urandom),
                              4'($urandom));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
